// File: rtl/reg_file.sv
// Architectural register file with rename tags for the out-of-order core.
// Renames on issue, resolves source lookups, retires on commit, drops tags on clear.
module reg_file #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 dec_ready,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           rd,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [4:0]           commit_reg_id,
    input  logic [31:0]          commit_val,
    output logic                 search_has_dep_1,
    output logic [ROB_WIDTH-1:0] search_rob_id_1,
    output logic [31:0]          search_val_1,
    output logic                 search_has_dep_2,
    output logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic [31:0]          search_val_2
);

    logic [31:0]          val_q  [REG_NUM];
    logic                 busy_q [REG_NUM];
    logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];

    logic rename_en;
    logic commit_en;

    assign rename_en = dec_ready && !clear && (rd != 5'd0);
    assign commit_en = commit_ready && (commit_reg_id != 5'd0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= 32'd0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                // Committed values are architectural and land even on clear.
                if (commit_en && commit_reg_id == 5'(i))
                    val_q[i] <= commit_val;
                if (clear) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end else if (rename_en && rd == 5'(i)) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= issue_rob_id;
                end else if (commit_en && commit_reg_id == 5'(i)
                             && tag_q[i] == commit_rob_id) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Returns {has_dep, rob_id, val}; reads pre-rename state so rd==rs sees the old producer.
    function automatic logic [ROB_WIDTH+32:0] lookup(
        input logic [4:0]           s,
        input logic                 b,
        input logic [ROB_WIDTH-1:0] t,
        input logic [31:0]          v
    );
        logic [ROB_WIDTH+32:0] r;
        r = '0;
        if (s == 5'd0) begin
            r = '0;
        end else if (!b) begin
            r = {1'b0, {ROB_WIDTH{1'b0}}, v};
        end else if (commit_ready && commit_reg_id == s
                     && commit_rob_id == t) begin
            r = {1'b0, {ROB_WIDTH{1'b0}}, commit_val};
        end else begin
            r = {1'b1, t, 32'd0};
        end
        return r;
    endfunction

    always_comb begin
        {search_has_dep_1, search_rob_id_1, search_val_1} =
            lookup(rs1, busy_q[rs1], tag_q[rs1], val_q[rs1]);
        {search_has_dep_2, search_rob_id_2, search_val_2} =
            lookup(rs2, busy_q[rs2], tag_q[rs2], val_q[rs2]);
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: behavioural model checked every cycle
// plus directed scenarios with literal expectations.
module tb_reg_file;

    localparam int RW = 4;

    logic          clk_in = 0;
    logic          rst_in = 1;
    logic          rdy_in = 1;
    logic          clear = 0;
    logic          dec_ready = 0;
    logic [4:0]    rs1 = 0, rs2 = 0, rd = 0;
    logic [RW-1:0] issue_rob_id = 0;
    logic          commit_ready = 0;
    logic [RW-1:0] commit_rob_id = 0;
    logic [4:0]    commit_reg_id = 0;
    logic [31:0]   commit_val = 0;
    logic          dep1, dep2;
    logic [RW-1:0] rid1, rid2;
    logic [31:0]   v1, v2;

    int checks = 0;
    int errors = 0;

    reg_file #(.ROB_WIDTH(RW), .REG_NUM(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .dec_ready(dec_ready), .rs1(rs1), .rs2(rs2), .rd(rd),
        .issue_rob_id(issue_rob_id), .commit_ready(commit_ready),
        .commit_rob_id(commit_rob_id), .commit_reg_id(commit_reg_id),
        .commit_val(commit_val),
        .search_has_dep_1(dep1), .search_rob_id_1(rid1), .search_val_1(v1),
        .search_has_dep_2(dep2), .search_rob_id_2(rid2), .search_val_2(v2)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model: architectural value plus "newest producer" per register.
    logic [31:0]   m_val  [32];
    bit            m_busy [32];
    logic [RW-1:0] m_tag  [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
    endtask

    initial model_reset();
    always @(posedge rst_in) model_reset();

    always @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            bit retire;
            int c, d;
            c = int'(commit_reg_id);
            d = int'(rd);
            retire = 0;
            if (commit_ready && c != 0) begin
                m_val[c] = commit_val;
                retire = (m_tag[c] == commit_rob_id);
            end
            if (clear) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 0; m_tag[i] = 0;
                end
            end else begin
                if (retire && !(dec_ready && d == c)) m_busy[c] = 0;
                if (dec_ready && d != 0) begin
                    m_busy[d] = 1; m_tag[d] = issue_rob_id;
                end
            end
        end
    end

    function automatic logic [RW+32:0] expect_src(input int s);
        if (s == 0) return '0;
        if (!m_busy[s]) return {1'b0, {RW{1'b0}}, m_val[s]};
        if (commit_ready && int'(commit_reg_id) == s && commit_rob_id == m_tag[s])
            return {1'b0, {RW{1'b0}}, commit_val};
        return {1'b1, m_tag[s], 32'd0};
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("model_port1", 64'({dep1, rid1, v1}), 64'(expect_src(int'(rs1))));
            chk("model_port2", 64'({dep2, rid2, v2}), 64'(expect_src(int'(rs2))));
        end
    end

    task automatic idle();
        clear = 0; dec_ready = 0; rd = 0; issue_rob_id = 0;
        commit_ready = 0; commit_rob_id = 0; commit_reg_id = 0; commit_val = 0;
        rdy_in = 1;
    endtask

    task automatic next();
        @(posedge clk_in); #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] r, input logic [RW-1:0] id);
        dec_ready = 1; rd = r; issue_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] r, input logic [RW-1:0] id,
                          input logic [31:0] v);
        commit_ready = 1; commit_reg_id = r; commit_rob_id = id; commit_val = v;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 0;

        // Reset: load x5, then assert reset mid-cycle
        commit(5, 0, 32'h55);
        next();
        rs1 = 5;
        @(negedge clk_in);
        chk("x5_loaded", 64'(v1), 64'h55);
        #2 rst_in = 1;
        #1;
        chk("rst_async_dep", 64'(dep1), 0);
        chk("rst_async_val", 64'(v1), 0);
        @(posedge clk_in); #1 rst_in = 0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i); #1;
            chk("rst_all_zero", 64'({dep1, rid1, v1, dep2, rid2, v2}), 0);
        end
        next();

        // Rename then commit with bypass
        issue(3, 7); next();
        rs1 = 3; @(negedge clk_in);
        chk("x3_dep", 64'({dep1, rid1}), 64'({1'b1, 4'd7}));
        next();
        rs1 = 3; commit(3, 7, 32'hDEADBEEF); @(negedge clk_in);
        chk("x3_bypass", 64'({dep1, v1}), 64'({1'b0, 32'hDEADBEEF}));
        next();
        rs1 = 3; @(negedge clk_in);
        chk("x3_retired", 64'({dep1, v1}), 64'({1'b0, 32'hDEADBEEF}));

        // Stale commit keeps the newer producer
        next(); issue(4, 2);
        next(); issue(4, 5);
        next(); commit(4, 2, 32'h11);
        next(); rs1 = 4; @(negedge clk_in);
        chk("x4_stale", 64'({dep1, rid1}), 64'({1'b1, 4'd5}));
        chk("x4_val", 64'(dut.val_q[4]), 64'h11);

        // Same-cycle rename and commit on x6
        next(); issue(6, 1);
        next(); commit(6, 1, 32'h22); issue(6, 9); rs1 = 6;
        @(negedge clk_in);
        chk("x6_bypass", 64'({dep1, v1}), 64'({1'b0, 32'h22}));
        next(); rs1 = 6; @(negedge clk_in);
        chk("x6_renamed", 64'({dep1, rid1}), 64'({1'b1, 4'd9}));

        // Clear with simultaneous commit and issue
        next(); issue(1, 3);
        next(); issue(2, 4);
        next(); issue(3, 10);
        next(); clear = 1; commit(2, 4, 32'h33); issue(8, 11);
        next(); rs1 = 2; rs2 = 1; @(negedge clk_in);
        chk("clr_x2", 64'({dep1, v1}), 64'({1'b0, 32'h33}));
        chk("clr_x1", 64'({dep2, v2}), 0);
        next(); rs1 = 3; rs2 = 8; @(negedge clk_in);
        chk("clr_x3", 64'({dep1, v1}), 64'({1'b0, 32'hDEADBEEF}));
        chk("clr_x8", 64'({dep2, rid2, v2}), 0);
        next(); rs1 = 6; @(negedge clk_in);
        chk("clr_x6", 64'({dep1, v1}), 64'({1'b0, 32'h22}));

        // x0 is never written nor busy
        next(); commit(0, 0, 32'h44); issue(0, 12);
        next(); rs1 = 0; @(negedge clk_in);
        chk("x0_zero", 64'({dep1, rid1, v1}), 0);

        // rdy_in low freezes state
        next(); commit(7, 0, 32'h77);
        next(); rdy_in = 0; issue(7, 13); commit(7, 0, 32'h78); rs1 = 7;
        @(negedge clk_in);
        chk("x7_stall_read", 64'({dep1, v1}), 64'({1'b0, 32'h77}));
        next(); rs1 = 7; @(negedge clk_in);
        chk("x7_frozen", 64'({dep1, v1}), 64'({1'b0, 32'h77}));

        next(); next();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the out-of-order core: 32 x 32-bit integer registers, each with a busy bit and the ROB id of its newest in-flight producer.
- Sits between the decoder and the ROB:
  - Renames rd on issue.
  - Answers the two source-operand queries that the ROB resolves and forwards to the RS/LSB.
  - Retires values on ROB commit.
  - Drops all rename state on a misprediction clear.

Parameters:
ROB_WIDTH, 4, bits of a ROB id (ROB_SIZE = 2**ROB_WIDTH)
REG_NUM, 32, number of architectural registers (x0 hard-wired to zero)

Ports:
clk_in  in  1  system clock; all state updates on rising edge
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global enable; state holds when low
clear  in  1  ROB misprediction flush
dec_ready  in  1  decoder issues one instruction this cycle
rs1  in  5  source register 1 of issuing instruction
rs2  in  5  source register 2 of issuing instruction
rd  in  5  destination register (0 = none: branch/store)
issue_rob_id  in  ROB_WIDTH  ROB entry allocated to the issuing instruction (ROB empty_rob_id)
commit_ready  in  1  ROB commits a register write
commit_rob_id  in  ROB_WIDTH  ROB id being committed
commit_reg_id  in  5  destination register of commit
commit_val  in  32  committed value
search_has_dep_1  out  1  rs1 waits on an in-flight producer
search_rob_id_1  out  ROB_WIDTH  producer ROB id for rs1 (0 if no dep)
search_val_1  out  32  rs1 value (0 if dep)
search_has_dep_2  out  1  as above, rs2
search_rob_id_2  out  ROB_WIDTH  as above, rs2
search_val_2  out  32  as above, rs2

Behaviour:
- State: val[0..31] (32b), busy[0..31], tag[0..31] (ROB_WIDTH).
- Reset (async, rst_in=1): all val, busy and tag = 0 immediately. Search outputs therefore read has_dep=0, rob_id=0, val=0 for any source.
- rdy_in=0: no state changes; search outputs remain combinationally valid.
- Search (combinational, zero latency), per port k with source s:
  - s=0: has_dep=0, rob_id=0, val=0.
  - busy[s]=0: has_dep=0, val=val[s].
  - busy[s]=1, commit_ready=1, commit_reg_id=s, commit_rob_id=tag[s]: commit bypass; has_dep=0, val=commit_val.
  - Otherwise: has_dep=1, rob_id=tag[s], val=0.
  - Lookup reflects state before this cycle's rename. An instruction with rd==rs sees the old producer, never itself.
- Commit (commit_ready=1 and rdy_in=1, reg r=commit_reg_id):
  - r=0: ignored.
  - Otherwise val[r] <= commit_val.
  - busy[r] <= 0 only if tag[r]==commit_rob_id and no rename of r happens this same cycle. A newer in-flight producer keeps r busy.
- Rename (dec_ready=1, rdy_in=1, clear=0, rd!=0): busy[rd] <= 1, tag[rd] <= issue_rob_id.
  - Rename wins over commit on the same register in the same cycle: busy stays 1 and the tag becomes issue_rob_id; the value is still written.
- Clear (clear=1, rdy_in=1):
  - All busy <= 0; tags <= 0.
  - A simultaneous commit still writes val, because committed state is architectural.
  - A simultaneous dec_ready is ignored (no rename).
- x0 is never written and never busy.
- ROB id wrap-around needs no special handling: tag equality is exact over ROB_WIDTH bits, and the ROB guarantees at most one live entry per id.

Test Plan:
1. Reset: assert rst_in asynchronously mid-cycle, rs1=5 -> outputs immediately has_dep=0, val=0; after release all regs read 0.
2. Rename then commit: issue rd=3, issue_rob_id=7 -> next cycle rs1=3 gives has_dep=1, rob_id=7. Commit (rob_id=7, reg=3, val=0xDEADBEEF) -> the same cycle bypasses val=0xDEADBEEF, has_dep=0; afterwards busy[3]=0 and val[3]=0xDEADBEEF.
3. Stale commit: rename x4 -> id 2, then x4 -> id 5. Commit id 2 with val 0x11 -> val[4]=0x11, rs1=4 still has_dep=1, rob_id=5.
4. Same-cycle rename+commit on x6: commit id 1 val 0x22 while issuing rd=6 id 9 with rs1=6 -> rs1 result has_dep=0, val=0x22. Next cycle rs1=6 gives has_dep=1, rob_id=9.
5. Clear: x1..x3 busy, clear=1 with commit (x2, 0x33) and dec_ready (rd=8) -> all busy=0, val[2]=0x33, x8 not busy.
6. x0 and rdy_in: commit reg 0 val 0x44 and issue rd=0 -> x0 reads 0, not busy. With rdy_in=0, commit/issue on x7 -> no change.
